fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I core; sits directly upstream of decode and sign-extension.
- Holds the fetch PC and issues one instruction-memory request at a time over a ready/valid interface.
- Presents a registered instruction and its PC to decode, which builds ImmOp from that instruction.
- Takes the branch decision (PCsrc, ImmOp) back from decode and redirects to PC + ImmOp.

Parameters:
- DATA_WIDTH, 32, width of PC, instruction and immediate.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  DATA_WIDTH  fetch address; bits [1:0] always 0.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  DATA_WIDTH  fetched instruction word.
- stall  input  1  decode cannot accept a new instruction this cycle.
- PCsrc  input  1  taken branch for the instruction currently on instr/PC.
- ImmOp  input  DATA_WIDTH  branch offset from sign extension; two's complement.
- instr_valid  output  1  instr/PC hold a live instruction.
- instr  output  DATA_WIDTH  instruction word to decode.
- PC  output  DATA_WIDTH  address of instr.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc_f = RESET_PC, state = FETCH.
  - instr_valid = 0, instr = NOP (32'h0000_0013), PC = 0.
  - Skid buffer empty, discard flag = 0.
  - imem_req = 0 while rst_n is low.
  - Reset mid-transaction abandons any outstanding response; a late imem_rvalid after release is ignored because state is FETCH.
- Handshake definitions:
  - consume = instr_valid && !stall.
  - out_free = !instr_valid || !stall.
  - PCsrc is sampled only when consume is 1 and is ignored otherwise.
- State FETCH:
  - imem_req = 1, imem_addr = pc_f.
  - On imem_ready, go to WAIT.
- State WAIT:
  - imem_req = 0.
  - On imem_rvalid with discard set: drop the data, clear discard, go to FETCH.
  - On imem_rvalid with out_free: next edge loads instr = imem_rdata, PC = pc_f, instr_valid = 1; pc_f += 4; go to FETCH.
  - On imem_rvalid without out_free: capture the data and its PC in the skid buffer; pc_f += 4; go to HOLD.
- State HOLD:
  - imem_req = 0.
  - When out_free, move the skid buffer to the output register, set instr_valid = 1, go to FETCH.
- Output register:
  - If consume occurs and nothing new is loaded that cycle, instr_valid goes to 0.
  - instr and PC are held while stall is high.
- Redirect (consume && PCsrc):
  - target = PC + ImmOp, modulo 2^DATA_WIDTH (wrap-around permitted), with bits [1:0] forced to 0.
  - pc_f <= target.
  - instr_valid <= 0 on the next edge.
  - FETCH: stay in FETCH; imem_addr shows target next cycle. The unaccepted request is retargeted.
  - Redirect and imem_ready in the same cycle: the accepted (wrong-path) request is marked discard, go to WAIT.
  - WAIT: set discard. If imem_rvalid arrives in the same cycle, drop that data and go to FETCH.
  - HOLD: empty the skid buffer, go to FETCH.
- Sequential PC increment wraps 32'hFFFF_FFFC -> 0.
- Latency: output loads on the edge after imem_rvalid. At most one request is outstanding, so the best case is one instruction every 2 cycles.

Decomposition:
- Package riscv_pkg:
  - NOP_INSTR constant.
  - fetch_state_t enum {FETCH, WAIT, HOLD}.
  - Default RESET_PC.
- One natural sub-module, pc_next, which is combinational: selects pc_f + 4 or PC + ImmOp and masks bits [1:0].
- The FSM, skid buffer and output register stay in fetch_unit.

Test Plan:
- Reset release, imem_ready = 1, rvalid one cycle after accept, rdata = 32'h00500093: imem_addr = 0, then 4; instr_valid rises with instr = 32'h00500093, PC = 0.
- stall = 1 for 3 cycles while a second response (32'h00A00113 @ 4) arrives: skid holds it, no new request, instr/PC unchanged. After stall drops, instr = 32'h00A00113, PC = 4 next edge, then a request to 8.
- PCsrc = 1 with PC = 8, ImmOp = 32'hFFFFFFF8 while a request is in WAIT: that response is dropped, next imem_addr = 0, instr_valid = 0 until the new data arrives.
- PCsrc = 1 with PC = 32'h100, ImmOp = 32'h0000000E: imem_addr = 32'h10C (bit 1 masked). PCsrc with stall = 1: ignored, no redirect.
- rst_n pulsed low while in WAIT: outputs return to reset values immediately. A stale imem_rvalid after release is ignored, and the first request is to RESET_PC.
- PC wrap: pc_f = 32'hFFFFFFFC fetch completes, next imem_addr = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the RV32I front end.
//               NOP_INSTR        - canonical NOP (addi x0, x0, 0)
//               DEFAULT_RESET_PC - default first fetch address
//               fetch_state_t    - fetch sequencer states
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,   // request outstanding on the bus, waiting for acceptance
    WAIT  = 2'd1,   // request accepted, waiting for read data
    HOLD  = 2'd2    // data parked in the skid buffer, decode is stalled
  } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pc_next.sv
`default_nettype none
// ============================================================================
// Module      : pc_next
// Description : Next fetch address. Selects the sequential address
//               (pc_f + 4) or the branch target (pc + imm_op). The sum wraps
//               modulo 2^DATA_WIDTH, and bits [1:0] are forced to zero so the
//               fetch address is always word aligned.
// Ports       : pc_f     in  current fetch PC
//               pc       in  PC of the instruction presented to decode
//               imm_op   in  two's complement branch offset
//               redirect in  1 = branch target, 0 = sequential
//               pc_nxt   out word-aligned next fetch address
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc_f,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm_op,
  input  logic                  redirect,
  output logic [DATA_WIDTH-1:0] pc_nxt
);

  logic [DATA_WIDTH-1:0] sum;

  always_comb begin
    sum = redirect ? (pc + imm_op) : (pc_f + DATA_WIDTH'(4));
    pc_nxt = {sum[DATA_WIDTH-1:2], 2'b00};
  end

endmodule : pc_next
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction-fetch stage. Keeps the fetch PC, issues one
//               instruction-memory request at a time, and presents a
//               registered instruction/PC pair to decode. A one-entry skid
//               buffer absorbs a response that arrives while decode is
//               stalled. A taken branch from decode redirects fetch to
//               PC + ImmOp.
// Ports       : clk, rst_n                       clock, async active-low reset
//               imem_req/imem_addr/imem_ready    request channel
//               imem_rvalid/imem_rdata           response channel
//               stall                            decode back-pressure
//               PCsrc/ImmOp                      branch decision from decode
//               instr_valid/instr/PC             instruction to decode
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] PC
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_f_q, pc_f_d;
  logic                  discard_q, discard_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;

  logic                  consume;
  logic                  out_free;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] pc_nxt;

  assign consume  = instr_valid_q && !stall;
  assign out_free = !instr_valid_q || !stall;
  // PCsrc belongs to the instruction on the output, so it only counts when
  // that instruction is actually taken by decode.
  assign redirect = consume && PCsrc;

  // One adder serves both uses: when redirect is low it yields pc_f + 4,
  // which is what every non-redirect update of pc_f needs.
  pc_next #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pc_next (
    .pc_f     (pc_f_q),
    .pc       (pc_q),
    .imm_op   (ImmOp),
    .redirect (redirect),
    .pc_nxt   (pc_nxt)
  );

  // State resets to FETCH, so the request must be gated by rst_n directly
  // to stay quiet while reset is held.
  assign imem_req    = rst_n && (state_q == FETCH);
  assign imem_addr   = pc_f_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign PC          = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    discard_d     = discard_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    pc_d          = pc_q;

    // Output drains on consume; a load below overrides this.
    if (consume) begin
      instr_valid_d = 1'b0;
    end

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_f_d = pc_nxt;
        end
        if (imem_ready) begin
          state_d = WAIT;
          // The request accepted this cycle was for the old path.
          if (redirect) begin
            discard_d = 1'b1;
          end
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (redirect || discard_q) begin
            discard_d = 1'b0;
            state_d   = FETCH;
            if (redirect) begin
              pc_f_d = pc_nxt;
            end
          end else if (out_free) begin
            instr_d       = imem_rdata;
            pc_d          = pc_f_q;
            instr_valid_d = 1'b1;
            pc_f_d        = pc_nxt;
            state_d       = FETCH;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_f_q;
            pc_f_d       = pc_nxt;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
          pc_f_d    = pc_nxt;
        end
      end

      HOLD: begin
        if (redirect) begin
          // Skid content is on the wrong path; leaving HOLD empties it.
          pc_f_d  = pc_nxt;
          state_d = FETCH;
        end else if (out_free) begin
          instr_d       = skid_instr_q;
          pc_d          = skid_pc_q;
          instr_valid_d = 1'b1;
          state_d       = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_f_q        <= RESET_PC;
      discard_q     <= 1'b0;
      skid_instr_q  <= DATA_WIDTH'(NOP_INSTR);
      skid_pc_q     <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= DATA_WIDTH'(NOP_INSTR);
      pc_q          <= '0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      discard_q     <= discard_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
    end
  end

endmodule : fetch_unit
`default_nettype wire
